divisor_clock: RTL

DIVISOR_CLOCK -- requirements
Module: divisor_clock

---
 rtl/divisor_clock.sv | 126 ++++++++++++
 1 files changed

// File: rtl/divisor_clock.sv
// divisor_clock: derives eight 50%-duty clocks (1 Hz .. 12.5 MHz) plus one-cycle rise strobes from one clock.
// Latency: clock_f first reads 1 after HALF_f enabled edges following reset or sync_clear; tick_f rises in that same cycle.
// Backpressure: none; enable=0 freezes counters and clocks and forces ticks low, sync_clear realigns everything.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   enable       1 = dividers advance, 0 = hold
//   sync_clear   synchronous realignment (wins over enable)
//   clock_*      registered divided clocks
//   tick_*       registered one-cycle strobes on each clock_* 0->1
module divisor_clock #(
  parameter int unsigned CLK_FREQ_HZ = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic sync_clear,
  output logic clock_1hz,
  output logic clock_10hz,
  output logic clock_100hz,
  output logic clock_1khz,
  output logic clock_10khz,
  output logic clock_100khz,
  output logic clock_1mhz,
  output logic clock_12mhz,
  output logic tick_1hz,
  output logic tick_10hz,
  output logic tick_100hz,
  output logic tick_1khz,
  output logic tick_10khz,
  output logic tick_100khz,
  output logic tick_1mhz,
  output logic tick_12mhz
);

  localparam int NUM_RATES = 8;

  // Half-period in clock cycles for rate index 0 (1 Hz) .. 7 (fixed quarter-rate).
  function automatic int unsigned half_of(input int idx);
    case (idx)
      0:       half_of = CLK_FREQ_HZ / 2;
      1:       half_of = CLK_FREQ_HZ / 20;
      2:       half_of = CLK_FREQ_HZ / 200;
      3:       half_of = CLK_FREQ_HZ / 2000;
      4:       half_of = CLK_FREQ_HZ / 20000;
      5:       half_of = CLK_FREQ_HZ / 200000;
      6:       half_of = CLK_FREQ_HZ / 2000000;
      default: half_of = 2;
    endcase
  endfunction

  logic [NUM_RATES-1:0] clk_vec;
  logic [NUM_RATES-1:0] tick_vec;

  for (genvar gi = 0; gi < NUM_RATES; gi++) begin : g_rate
    localparam int unsigned HALF = half_of(gi);

    if (HALF == 0) begin : g_off
      // Rate not reachable from this input clock.
      assign clk_vec[gi]  = 1'b0;
      assign tick_vec[gi] = 1'b0;
    end else begin : g_div
      localparam int W = (HALF > 1) ? $clog2(HALF) : 1;
      localparam logic [W-1:0] LAST = W'(HALF - 1);

      logic [W-1:0] cnt_q, cnt_d;
      logic         clk_q, clk_d;
      logic         tick_q, tick_d;

      always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sync_clear) begin
          cnt_d = '0;
          clk_d = 1'b0;
        end else if (enable) begin
          if (cnt_q == LAST) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            // Strobe only on the low->high toggle, registered alongside clk_q.
            tick_d = ~clk_q;
          end else begin
            cnt_d = cnt_q + W'(1);
          end
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          cnt_q  <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          clk_q  <= clk_d;
          tick_q <= tick_d;
        end
      end

      assign clk_vec[gi]  = clk_q;
      assign tick_vec[gi] = tick_q;
    end
  end

  // Plain wiring from the flops; no logic between register and pin.
  assign clock_1hz    = clk_vec[0];
  assign clock_10hz   = clk_vec[1];
  assign clock_100hz  = clk_vec[2];
  assign clock_1khz   = clk_vec[3];
  assign clock_10khz  = clk_vec[4];
  assign clock_100khz = clk_vec[5];
  assign clock_1mhz   = clk_vec[6];
  assign clock_12mhz  = clk_vec[7];

  assign tick_1hz     = tick_vec[0];
  assign tick_10hz    = tick_vec[1];
  assign tick_100hz   = tick_vec[2];
  assign tick_1khz    = tick_vec[3];
  assign tick_10khz   = tick_vec[4];
  assign tick_100khz  = tick_vec[5];
  assign tick_1mhz    = tick_vec[6];
  assign tick_12mhz   = tick_vec[7];

endmodule
